// File: rtl/fft_pkg.sv
// Shared types and index helpers for the FFT front end.
// The deserializer state encoding and the bit-reverse lane mapping live here.
package fft_pkg;

    typedef enum logic [0:0] {
        COLLECT = 1'b0,
        OUTPUT  = 1'b1
    } deser_state_e;

    // Counter width for a frame of n samples (n is a power of two, n >= 2).
    function automatic int log2_width(input int n);
        return $clog2(n);
    endfunction

    // Reverse the low 'width' bits of idx; bits above 'width' are dropped.
    function automatic int bit_reverse(input int idx, input int width);
        int r;
        r = 32'sd0;
        for (int i = 0; i < 32; i++) begin
            if (i < width) begin
                r[width - 1 - i] = idx[i];
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/fft_deserializer_if.sv
// Sample-stream and frame handshake bundle between the producer, the
// deserializer and the first FFT stage.
interface fft_deserializer_if #(
    parameter int BIT_WIDTH = 32,
    parameter int N_SAMPLES = 8
);
    logic [BIT_WIDTH-1:0]                recv_msg;
    logic                                recv_val;
    logic                                recv_rdy;
    logic [N_SAMPLES-1:0][BIT_WIDTH-1:0] send_msg_real;
    logic [N_SAMPLES-1:0][BIT_WIDTH-1:0] send_msg_imag;
    logic                                send_val;
    logic                                send_rdy;

    modport master (
        output recv_msg, recv_val, send_rdy,
        input  recv_rdy, send_msg_real, send_msg_imag, send_val
    );

    modport slave (
        input  recv_msg, recv_val, send_rdy,
        output recv_rdy, send_msg_real, send_msg_imag, send_val
    );
endinterface

// File: rtl/fft_deserializer.sv
// Collects N_SAMPLES real samples into a frame buffer and hands the whole
// frame to the first FFT stage; optional bit-reversed lane placement.
module fft_deserializer
    import fft_pkg::*;
#(
    parameter int BIT_WIDTH   = 32,
    parameter int DECIMAL_PT  = 16,
    parameter int N_SAMPLES   = 8,
    parameter int BIT_REVERSE = 0
) (
    input  logic              clk,
    input  logic              reset,
    fft_deserializer_if.slave bus
);

    localparam int CNT_W = log2_width(N_SAMPLES);

    if (N_SAMPLES < 2 || (N_SAMPLES & (N_SAMPLES - 1)) != 0) begin : g_bad_n
        $error("N_SAMPLES must be a power of two and at least 2");
    end
    if (DECIMAL_PT < 0 || DECIMAL_PT > BIT_WIDTH) begin : g_bad_dp
        $error("DECIMAL_PT must lie within BIT_WIDTH");
    end

    deser_state_e          state_r;
    deser_state_e          state_next_s;
    logic [CNT_W-1:0]      cnt_r;
    logic [CNT_W-1:0]      cnt_next_s;
    logic [CNT_W-1:0]      lane_sel_s;
    logic [N_SAMPLES-1:0]  lane_we_s;
    logic                  recv_fire_s;
    logic [BIT_WIDTH-1:0]  buf_r [N_SAMPLES];

    // Handshake flags come straight from the state register, never from val/rdy inputs.
    assign bus.recv_rdy = (state_r == COLLECT);
    assign bus.send_val = (state_r == OUTPUT);
    assign recv_fire_s  = bus.recv_val && (state_r == COLLECT);

    // Lane addressed by the current sample index.
    always_comb begin
        if (BIT_REVERSE != 0) begin
            lane_sel_s = CNT_W'(bit_reverse(int'(cnt_r), CNT_W));
        end else begin
            lane_sel_s = cnt_r;
        end
    end

    for (genvar g = 0; g < N_SAMPLES; g++) begin : g_lane
        assign lane_we_s[g] = recv_fire_s && (lane_sel_s == CNT_W'(g));

        // Per-lane frame storage: cleared on reset, otherwise overwritten in place.
        always_ff @(posedge clk) begin
            if (reset) begin
                buf_r[g] <= '0;
            end else if (lane_we_s[g]) begin
                buf_r[g] <= bus.recv_msg;
            end else begin
                buf_r[g] <= buf_r[g];
            end
        end
    end

    // Frame outputs mirror the buffer; imaginary lanes are always zero.
    always_comb begin
        for (int i = 0; i < N_SAMPLES; i++) begin
            bus.send_msg_real[i] = buf_r[i];
            bus.send_msg_imag[i] = '0;
        end
    end

    // Next-state and sample-counter logic.
    always_comb begin
        state_next_s = state_r;
        cnt_next_s   = cnt_r;
        case (state_r)
            COLLECT: begin
                if (recv_fire_s) begin
                    // Counter wraps naturally to zero on the last sample.
                    cnt_next_s = cnt_r + 1'b1;
                    if (cnt_r == CNT_W'(N_SAMPLES - 1)) begin
                        state_next_s = OUTPUT;
                    end else begin
                        state_next_s = COLLECT;
                    end
                end else begin
                    state_next_s = COLLECT;
                end
            end
            OUTPUT: begin
                if (bus.send_rdy) begin
                    state_next_s = COLLECT;
                end else begin
                    state_next_s = OUTPUT;
                end
            end
            default: begin
                state_next_s = COLLECT;
                cnt_next_s   = '0;
            end
        endcase
    end

    // State and counter registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= COLLECT;
            cnt_r   <= '0;
        end else begin
            state_r <= state_next_s;
            cnt_r   <= cnt_next_s;
        end
    end

endmodule

// File: tb/tb_fft_deserializer.sv
// Scoreboard bench: one stimulus stream drives an in-order and a bit-reversed
// deserializer side by side; monitors pop expected frames on each send handshake.
module tb_fft_deserializer;

    typedef logic [7:0][31:0] frame_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] recv_msg = 32'd0;
    logic        recv_val = 1'b0;
    logic        send_rdy = 1'b1;

    int n_checks = 0;
    int n_pass   = 0;

    frame_t q_nat[$];
    frame_t q_rev[$];
    frame_t part;
    frame_t last_nat;
    int     pcnt = 0;
    // Hand-derived 3-bit reversal: sample k lands in lane rev_lane[k].
    int     rev_lane [8] = '{0, 4, 2, 6, 1, 5, 3, 7};

    fft_deserializer_if #(.BIT_WIDTH(32), .N_SAMPLES(8)) nat_if ();
    fft_deserializer_if #(.BIT_WIDTH(32), .N_SAMPLES(8)) rev_if ();

    assign nat_if.recv_msg = recv_msg;
    assign nat_if.recv_val = recv_val;
    assign nat_if.send_rdy = send_rdy;
    assign rev_if.recv_msg = recv_msg;
    assign rev_if.recv_val = recv_val;
    assign rev_if.send_rdy = send_rdy;

    fft_deserializer #(.BIT_WIDTH(32), .DECIMAL_PT(16), .N_SAMPLES(8), .BIT_REVERSE(0)) u_nat (
        .clk   (clk),
        .reset (reset),
        .bus   (nat_if.slave)
    );

    fft_deserializer #(.BIT_WIDTH(32), .DECIMAL_PT(16), .N_SAMPLES(8), .BIT_REVERSE(1)) u_rev (
        .clk   (clk),
        .reset (reset),
        .bus   (rev_if.slave)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] lanes_or(input frame_t f);
        logic [31:0] r;
        r = 32'd0;
        for (int i = 0; i < 8; i++) r = r | f[i];
        return r;
    endfunction

    // Sample one handshake into both DUTs and update the frame model.
    task automatic push(input logic [31:0] v);
        int   guard;
        logic hs;
        frame_t er;
        guard    = 0;
        recv_val = 1'b1;
        recv_msg = v;
        forever begin
            @(negedge clk);
            hs = nat_if.recv_rdy;
            @(posedge clk);
            #1;
            if (hs) break;
            guard++;
            if (guard > 100) begin
                check("push_timeout", 32'd1, 32'd0);
                break;
            end
        end
        recv_val = 1'b0;
        part[pcnt] = v;
        pcnt++;
        if (pcnt == 8) begin
            for (int k = 0; k < 8; k++) er[rev_lane[k]] = part[k];
            q_nat.push_back(part);
            q_rev.push_back(er);
            last_nat = part;
            pcnt = 0;
        end
    endtask

    task automatic check_idle(input string name);
        check({name, "_rdy"},   {31'd0, nat_if.recv_rdy}, 32'd1);
        check({name, "_val"},   {31'd0, nat_if.send_val}, 32'd0);
        check({name, "_lanes"}, lanes_or(nat_if.send_msg_real) | lanes_or(rev_if.send_msg_real), 32'd0);
        check({name, "_imag"},  lanes_or(nat_if.send_msg_imag) | lanes_or(rev_if.send_msg_imag), 32'd0);
    endtask

    // Monitor: mutual exclusion every cycle, frame contents on every send handshake.
    always @(negedge clk) begin
        frame_t e;
        if (!reset) begin
            check("excl_nat", {31'd0, nat_if.recv_rdy & nat_if.send_val}, 32'd0);
            check("excl_rev", {31'd0, rev_if.recv_rdy & rev_if.send_val}, 32'd0);
            if (nat_if.send_val && send_rdy) begin
                if (q_nat.size() == 0) begin
                    check("sb_nat_unexpected", 32'd1, 32'd0);
                end else begin
                    e = q_nat.pop_front();
                    for (int i = 0; i < 8; i++) begin
                        check($sformatf("nat_lane%0d", i), nat_if.send_msg_real[i], e[i]);
                    end
                    check("nat_imag", lanes_or(nat_if.send_msg_imag), 32'd0);
                end
            end
            if (rev_if.send_val && send_rdy) begin
                if (q_rev.size() == 0) begin
                    check("sb_rev_unexpected", 32'd1, 32'd0);
                end else begin
                    e = q_rev.pop_front();
                    for (int i = 0; i < 8; i++) begin
                        check($sformatf("rev_lane%0d", i), rev_if.send_msg_real[i], e[i]);
                    end
                    check("rev_imag", lanes_or(rev_if.send_msg_imag), 32'd0);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Reset then idle.
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            check_idle("idle");
        end
        @(posedge clk);
        #1;

        // In-order fill, back-to-back, downstream ready.
        send_rdy = 1'b1;
        for (int k = 1; k <= 8; k++) push(32'(k));
        @(negedge clk);
        check("lat_val", {31'd0, nat_if.send_val}, 32'd1);
        check("lat_rdy", {31'd0, nat_if.recv_rdy}, 32'd0);
        @(posedge clk);
        #1;
        check("rdy_back", {31'd0, nat_if.recv_rdy}, 32'd1);

        // Fixed-point ramp, exercises the bit-reversed ordering.
        for (int k = 0; k < 8; k++) push(32'h0001_0000 * 32'(k));
        repeat (2) @(posedge clk);
        #1;

        // Backpressure with garbage offered while the frame is held.
        send_rdy = 1'b0;
        for (int k = 0; k < 8; k++) push(32'h0000_00A0 + 32'(k));
        for (int c = 0; c < 5; c++) begin
            recv_val = 1'b1;
            recv_msg = 32'hDEAD_0000 + 32'(c);
            @(negedge clk);
            check("bp_val", {31'd0, nat_if.send_val}, 32'd1);
            check("bp_rdy", {31'd0, nat_if.recv_rdy}, 32'd0);
            for (int i = 0; i < 8; i++) begin
                check("bp_hold", nat_if.send_msg_real[i], last_nat[i]);
            end
            @(posedge clk);
            #1;
        end
        recv_val = 1'b0;
        send_rdy = 1'b1;
        @(posedge clk);
        #1;
        check("bp_release_rdy", {31'd0, nat_if.recv_rdy}, 32'd1);
        check("bp_release_val", {31'd0, nat_if.send_val}, 32'd0);

        // Bubbly input: valid pattern 1,0,0 repeating over two frames.
        for (int f = 0; f < 2; f++) begin
            for (int k = 0; k < 8; k++) begin
                push(32'h0000_0200 + 32'(f * 16 + k));
                repeat (2) @(posedge clk);
                #1;
            end
        end

        // Reset mid-frame discards partial data.
        for (int k = 0; k < 5; k++) push(32'h0000_0550 + 32'(k));
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        pcnt  = 0;
        @(negedge clk);
        check_idle("rst_mid");
        @(posedge clk);
        #1;
        for (int k = 101; k <= 108; k++) push(32'(k));

        repeat (4) @(posedge clk);
        #1;
        check("sb_nat_drain", 32'(q_nat.size()), 32'd0);
        check("sb_rev_drain", 32'(q_rev.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
